sha_256_nonce_search: RTL and testbench

Nonce-sweep controller that drives a `sha_256` instance and consumes its results. It issues one candidate message per cycle, formed as a fixed prefix plus an incrementing nonce, over a programmed nonce range. Results come back in order; it tags each with its nonce through an in-order tag FIFO and compares it against a 256-bit target. It reports the first hitting nonce and a hit count, and sits directly around `sha_256`, feeding `in_valid`/`word` and consuming `hash`/`out_valid`.

---
 rtl/sha_256_nonce_search.sv | 257 +++++++++++++++++++++++++
 tb/tb_sha_256_nonce_search.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_256_nonce_search.sv
// ---------------------------------------------------------------------------
// sha_256_nonce_search
//
// Nonce-sweep controller wrapped around a pipelined sha_256 core. After an
// accepted start it issues {prefix, nonce} for every nonce from nonce_first
// to nonce_last (inclusive, wrapping mod 2^NONCE_W), one per cycle. Each
// issued nonce is remembered in an in-order tag FIFO. Returning hashes are
// matched to the oldest tag and compared against the latched target. The
// block reports the first hitting nonce and a saturating hit count.
//
// Optional feature macro: SHA_SEARCH_STOP_ON_HIT_EN
//   defined   -> a hit seen while issuing stops further issuing at once;
//                in-flight results are still evaluated.
//   undefined -> the full range is always issued.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           launch a sweep (accepted only in IDLE)
//   prefix          message MSBs, latched on accept
//   nonce_first     first nonce, latched on accept
//   nonce_last      last nonce (inclusive), latched on accept
//   target          hit when hash < target (unsigned), latched on accept
//   busy            sweep or post-reset flush in progress
//   done            one-cycle pulse at the end of a sweep
//   found           at least one hit this sweep
//   found_nonce     first hitting nonce in issue order
//   hit_count       hits this sweep, saturating
//   sha_in_valid    to sha_256.in_valid
//   sha_word        to sha_256.word, {prefix, nonce}
//   sha_hash        from sha_256.hash
//   sha_out_valid   from sha_256.out_valid
//   dbg_state       current FSM state, for observation only
//
// Handshake: there is no back-pressure. sha_in_valid=1 means sha_word is a
// new message consumed by the core in that cycle; sha_out_valid=1 means
// sha_hash is the result of the oldest message still in flight. Results
// arrive in issue order, exactly PIPE_LATENCY cycles after their issue.
// ---------------------------------------------------------------------------
module sha_256_nonce_search #(
    parameter int LENGTH       = 256,
    parameter int NONCE_W      = 32,
    parameter int PIPE_LATENCY = 65,
    parameter int HIT_CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LENGTH-NONCE_W-1:0]   prefix,
    input  logic [NONCE_W-1:0]          nonce_first,
    input  logic [NONCE_W-1:0]          nonce_last,
    input  logic [255:0]                target,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [NONCE_W-1:0]          found_nonce,
    output logic [HIT_CNT_W-1:0]        hit_count,
    output logic                        sha_in_valid,
    output logic [LENGTH-1:0]           sha_word,
    input  logic [255:0]                sha_hash,
    input  logic                        sha_out_valid,
    output logic [2:0]                  dbg_state
);

    localparam int DEPTH = PIPE_LATENCY + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FL_W  = $clog2(PIPE_LATENCY + 1);
    localparam int PFX_W = LENGTH - NONCE_W;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [FL_W-1:0]        flush_cnt_q, flush_cnt_d;
    logic [PFX_W-1:0]       prefix_q, prefix_d;
    logic [NONCE_W-1:0]     last_q, last_d;
    logic [255:0]           target_q, target_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   found_q, found_d;
    logic [NONCE_W-1:0]     found_nonce_q, found_nonce_d;
    logic [HIT_CNT_W-1:0]   hit_count_q, hit_count_d;
    logic                   sha_in_valid_q, sha_in_valid_d;
    logic [LENGTH-1:0]      sha_word_q, sha_word_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NONCE_W-1:0]     tag_mem [DEPTH];

    logic                   push;
    logic                   pop;
    logic                   hit;
    logic [NONCE_W-1:0]     cur_nonce;
    logic [NONCE_W-1:0]     tag_head;

    // The nonce currently on the bus lives in the low bits of sha_word_q.
    assign cur_nonce = sha_word_q[NONCE_W-1:0];
    assign tag_head  = tag_mem[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // A tag is pushed in the same cycle the core sees the message.
        push = sha_in_valid_q;
        // Results with no outstanding tag are stale and ignored.
        pop  = sha_out_valid && (count_q != '0);
        hit  = pop && (sha_hash < target_q);

        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        prefix_d       = prefix_q;
        last_d         = last_q;
        target_d       = target_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        found_d        = found_q;
        found_nonce_d  = found_nonce_q;
        hit_count_d    = hit_count_q;
        sha_in_valid_d = sha_in_valid_q;
        sha_word_d     = sha_word_q;

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (hit) begin
            if (hit_count_q != '1) begin
                hit_count_d = hit_count_q + 1'b1;
            end
            if (!found_q) begin
                found_d       = 1'b1;
                found_nonce_d = tag_head;
            end
        end

        case (state_q)
            ST_FLUSH: begin
                // Let anything still inside the core drain out unmatched.
                busy_d = 1'b1;
                if (flush_cnt_q == FL_W'(PIPE_LATENCY - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    prefix_d       = prefix;
                    last_d         = nonce_last;
                    target_d       = target;
                    sha_word_d     = {prefix, nonce_first};
                    sha_in_valid_d = 1'b1;
                    busy_d         = 1'b1;
                    found_d        = 1'b0;
                    found_nonce_d  = '0;
                    hit_count_d    = '0;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef SHA_SEARCH_STOP_ON_HIT_EN
                if ((cur_nonce == last_q) || hit) begin
`else
                if (cur_nonce == last_q) begin
`endif
                    sha_in_valid_d = 1'b0;
                    state_d        = ST_DRAIN;
                end else begin
                    // Increment wraps naturally mod 2^NONCE_W.
                    sha_word_d = {prefix_q, cur_nonce + 1'b1};
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The done cycle ignores start; the next sweep can be
                // accepted from the following cycle on.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FLUSH;
            flush_cnt_q    <= '0;
            prefix_q       <= '0;
            last_q         <= '0;
            target_q       <= '0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            found_q        <= 1'b0;
            found_nonce_q  <= '0;
            hit_count_q    <= '0;
            sha_in_valid_q <= 1'b0;
            sha_word_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            prefix_q       <= prefix_d;
            last_q         <= last_d;
            target_q       <= target_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            found_q        <= found_d;
            found_nonce_q  <= found_nonce_d;
            hit_count_q    <= hit_count_d;
            sha_in_valid_q <= sha_in_valid_d;
            sha_word_q     <= sha_word_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Tag storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= cur_nonce;
        end
    end

    // busy_q is already 1 for the flush that follows reset; masking with rst
    // keeps busy low for as long as reset is held.
    assign busy         = busy_q & ~rst;
    assign done         = done_q;
    assign found        = found_q;
    assign found_nonce  = found_nonce_q;
    assign hit_count    = hit_count_q;
    assign sha_in_valid = sha_in_valid_q;
    assign sha_word     = sha_word_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sha_256_nonce_search.sv
// ---------------------------------------------------------------------------
// tb_sha_256_nonce_search
//
// Bench for sha_256_nonce_search. A sha_256 stand-in with PIPE_LATENCY
// cycles of delay returns a hash chosen per nonce (all-zero, a two-nonce
// hit set, or a pseudo-random mix). A reference model derives the issue
// sequence and the expected found/found_nonce/hit_count directly from the
// range, the target and the stub's hash rule.
// ---------------------------------------------------------------------------
module tb_sha_256_nonce_search;

    localparam int LENGTH    = 256;
    localparam int NONCE_W   = 32;
    localparam int L         = 65;
    localparam int HIT_CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                      start = 1'b0;
    logic [LENGTH-NONCE_W-1:0] prefix = '0;
    logic [NONCE_W-1:0]        nonce_first = '0;
    logic [NONCE_W-1:0]        nonce_last = '0;
    logic [255:0]              target = '0;
    logic                      busy;
    logic                      done;
    logic                      found;
    logic [NONCE_W-1:0]        found_nonce;
    logic [HIT_CNT_W-1:0]      hit_count;
    logic                      sha_in_valid;
    logic [LENGTH-1:0]         sha_word;
    logic [255:0]              sha_hash;
    logic                      sha_out_valid;
    logic [2:0]                dbg_state;

    sha_256_nonce_search #(
        .LENGTH       (LENGTH),
        .NONCE_W      (NONCE_W),
        .PIPE_LATENCY (L),
        .HIT_CNT_W    (HIT_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .prefix        (prefix),
        .nonce_first   (nonce_first),
        .nonce_last    (nonce_last),
        .target        (target),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .found_nonce   (found_nonce),
        .hit_count     (hit_count),
        .sha_in_valid  (sha_in_valid),
        .sha_word      (sha_word),
        .sha_hash      (sha_hash),
        .sha_out_valid (sha_out_valid),
        .dbg_state     (dbg_state)
    );

    // ---------------- sha_256 stand-in ----------------
    int          hash_mode = 0;   // 0: all zero, 1: hit set, 2: mixed
    bit [31:0]   hit_a = '0;
    bit [31:0]   hit_b = '0;
    bit [31:0]   seed  = '0;

    function automatic logic [255:0] stub_hash(input bit [31:0] n, input int mode,
                                               input bit [31:0] ha, input bit [31:0] hb,
                                               input bit [31:0] sd);
        bit [31:0] x;
        case (mode)
            0: return '0;
            1: return ((n == ha) || (n == hb)) ? 256'd0 : {256{1'b1}};
            default: begin
                x = n ^ sd;
                x = x * 32'h7feb352d;
                x = x ^ (x >> 15);
                x = x * 32'h846ca68b;
                x = x ^ (x >> 16);
                return {8{x}};
            end
        endcase
    endfunction

    bit        pipe_v [L];
    bit [31:0] pipe_n [L];
    always @(posedge clk) begin
        pipe_v[0] <= sha_in_valid;
        pipe_n[0] <= sha_word[31:0];
        for (int i = 1; i < L; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_n[i] <= pipe_n[i-1];
        end
    end
    assign sha_out_valid = pipe_v[L-1];
    assign sha_hash      = stub_hash(pipe_n[L-1], hash_mode, hit_a, hit_b, seed);

    // ---------------- scoreboard ----------------
    int                 n_assert = 0;
    int                 n_fail   = 0;
    logic [LENGTH-1:0]  exp_q[$];
    bit                 mon_en = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every issued word must be the next one the model predicted.
    always @(negedge clk) begin
        if (mon_en && sha_in_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("issue_extra", 256'(sha_in_valid), 256'd0);
            end else begin
                chk("issue_word", sha_word, exp_q.pop_front());
            end
        end
    end

    // Reference model: issue list and result summary from the range rules.
    task automatic model(input logic [31:0] first, input logic [31:0] last,
                         input logic [255:0] tgt, input logic [223:0] pfx,
                         output int issued, output logic f, output logic [31:0] fn,
                         output int hits);
        longint     k;
        longint     fh;
        logic [31:0] n;
        k  = longint'(last - first) + 1;
        fh = -1;
        for (longint i = 0; i < k; i++) begin
            n = first + 32'(i);
            if (fh < 0 && stub_hash(n, hash_mode, hit_a, hit_b, seed) < tgt) fh = i;
        end
        issued = int'(k);
`ifdef SHA_SEARCH_STOP_ON_HIT_EN
        // The hit is seen L cycles after its issue; that cycle still issues.
        if (fh >= 0 && fh + L + 1 < k) issued = int'(fh + L + 1);
`endif
        f = 1'b0; fn = '0; hits = 0;
        for (int i = 0; i < issued; i++) begin
            n = first + 32'(i);
            exp_q.push_back({pfx, n});
            if (stub_hash(n, hash_mode, hit_a, hit_b, seed) < tgt) begin
                if (hits < 65535) hits++;
                if (!f) begin
                    f  = 1'b1;
                    fn = n;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge while the DUT is idle; returns at cycle N+1.
    task automatic start_sweep(input logic [31:0] first, input logic [31:0] last,
                               input logic [255:0] tgt, input logic [223:0] pfx,
                               input bit hold, output int first_cyc);
        start       = 1'b1;
        prefix      = pfx;
        nonce_first = first;
        nonce_last  = last;
        target      = tgt;
        @(negedge clk);
        if (!hold) start = 1'b0;
        first_cyc = cyc;
        chk("first_busy", 256'(busy), 256'd1);
        chk("first_valid", 256'(sha_in_valid), 256'd1);
    endtask

    task automatic finish_check(input string tag, input int first_cyc, input int issued,
                                input logic f, input logic [31:0] fn, input int hits);
        int done_cyc;
        done_cyc = -1;
        for (int i = 0; i < issued + L + 20; i++) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc < 0) begin
            chk({tag, "_done_timeout"}, 256'(done), 256'd1);
        end else begin
            chk({tag, "_latency"}, 256'(done_cyc - first_cyc), 256'(issued + L));
            chk({tag, "_busy_at_done"}, 256'(busy), 256'd0);
            chk({tag, "_found"}, 256'(found), 256'(f));
            chk({tag, "_found_nonce"}, 256'(found_nonce), 256'(fn));
            chk({tag, "_hit_count"}, 256'(hit_count), 256'(hits));
            chk({tag, "_issues_left"}, 256'(exp_q.size()), 256'd0);
        end
    endtask

    task automatic sweep(input string tag, input logic [31:0] first, input logic [31:0] last,
                         input logic [255:0] tgt, input logic [223:0] pfx);
        int          issued, hits, fc;
        logic        f;
        logic [31:0] fn;
        @(negedge clk);
        model(first, last, tgt, pfx, issued, f, fn, hits);
        start_sweep(first, last, tgt, pfx, 1'b0, fc);
        finish_check(tag, fc, issued, f, fn, hits);
    endtask

    // Called #1 after the first negedge following the last reset edge.
    task automatic flush_check(input string tag);
        for (int i = 0; i < L; i++) begin
            chk({tag, "_flush_busy"}, 256'(busy), 256'd1);
            chk({tag, "_flush_valid"}, 256'(sha_in_valid), 256'd0);
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_flush_end_busy"}, 256'(busy), 256'd0);
        chk({tag, "_flush_end_valid"}, 256'(sha_in_valid), 256'd0);
    endtask

    task automatic random_sweep(input string tag, input logic [31:0] first);
        hash_mode = 2;
        seed      = $urandom;
        sweep(tag, first, first + 32'($urandom_range(0, 40)),
              {$urandom, 224'd0}, {7{$urandom}});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          issued, hits, fc, n_iss;
        logic        f;
        logic [31:0] fn;

        // Reset state while rst is held.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_found", 256'(found), 256'd0);
        chk("rst_found_nonce", 256'(found_nonce), 256'd0);
        chk("rst_hit_count", 256'(hit_count), 256'd0);
        chk("rst_valid", 256'(sha_in_valid), 256'd0);
        chk("rst_word", sha_word, 256'd0);
        rst = 1'b0;
        #1;
        flush_check("init");
        mon_en = 1'b1;

        // Range 0..3, every nonce hits.
        hash_mode = 0;
        sweep("all_hit", 32'd0, 32'd3, {256{1'b1}}, 224'hA5);
        // Range 0..3, nothing can be below zero.
        sweep("no_hit", 32'd0, 32'd3, 256'd0, 224'h5A);
        // Wrap through all-ones to zero.
        sweep("wrap", 32'hFFFF_FFFE, 32'd1, {256{1'b1}}, 224'h1234);
        // Single nonce range.
        sweep("single", 32'hDEAD_BEEF, 32'hDEAD_BEEF, {256{1'b1}}, 224'h77);
        // Only nonces 5 and 9 hit, over 0..199.
        hash_mode = 1; hit_a = 32'd5; hit_b = 32'd9;
        sweep("hit_5_9", 32'd0, 32'd199, 256'd1, 224'hCAFE);

        // Randomised sweeps, one starting just below the wrap point.
        for (int r = 0; r < 6; r++) random_sweep("rand", $urandom);
        random_sweep("rand_wrap", 32'hFFFF_FFFF - 32'($urandom_range(0, 20)));

        // Reset in the 10th issue cycle.
        @(negedge clk);
        hash_mode = 1; hit_a = 32'd5; hit_b = 32'd9;
        model(32'd0, 32'd199, 256'd1, 224'hBEEF, issued, f, fn, hits);
        start_sweep(32'd0, 32'd199, 256'd1, 224'hBEEF, 1'b0, fc);
        n_iss = 0;
        for (int i = 0; i < 30 && n_iss < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (sha_in_valid === 1'b1) n_iss++;
        end
        chk("pre_rst_issues", 256'(n_iss), 256'd10);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_hit_count", 256'(hit_count), 256'd0);
        chk("mid_rst_done", 256'(done), 256'd0);
        chk("mid_rst_word", sha_word, 256'd0);
        flush_check("mid");
        mon_en = 1'b1;
        sweep("post_rst", 32'd0, 32'd199, 256'd1, 224'hF00D);

        // start held through a sweep: one sweep, then one more after done.
        hash_mode = 0;
        @(negedge clk);
        model(32'd10, 32'd13, {256{1'b1}}, 224'h99, issued, f, fn, hits);
        start_sweep(32'd10, 32'd13, {256{1'b1}}, 224'h99, 1'b1, fc);
        finish_check("hold1", fc, issued, f, fn, hits);
        model(32'd10, 32'd13, {256{1'b1}}, 224'h99, issued, f, fn, hits);
        @(negedge clk);
        chk("hold_gap_busy", 256'(busy), 256'd0);
        chk("hold_gap_valid", 256'(sha_in_valid), 256'd0);
        @(negedge clk);
        start = 1'b0;
        fc = cyc;
        chk("hold_restart_busy", 256'(busy), 256'd1);
        finish_check("hold2", fc, issued, f, fn, hits);

        repeat (3) @(negedge clk);
        $display("final dbg_state=%0d", dbg_state);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
